// File: rtl/mips_bus_lsu_pkg.sv
// Shared types and helpers for the MIPS Avalon-MM load/store unit.
// Access sizes, FSM states and alignment/size decode.
package mips_bus_lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } lsu_size_t;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_BUS,
        LSU_RESP
    } lsu_state_t;

    // Bytes moved by an access; the unused encoding decodes as one byte
    function automatic int lsu_nbytes(input lsu_size_t s);
        case (s)
            SIZE_HALF: return 2;
            SIZE_WORD: return 4;
            default:   return 1;
        endcase
    endfunction

    // The unused size encoding is rejected like a misaligned access
    function automatic logic lsu_misaligned(input lsu_size_t s,
                                            input logic [1:0] lo);
        case (s)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return lo[0];
            SIZE_WORD: return |lo;
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mips_bus_lsu_lane_align.sv
// Byte-lane steering between core data and the Avalon data bus.
// Builds byteenable/writedata for stores and extracts/extends loads.
module mips_bus_lsu_lane_align
    import mips_bus_lsu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  lsu_size_t                      i_size,
    input  logic [$clog2(DATA_W/8)-1:0]    i_off,
    input  logic                           i_signed,
    input  logic [31:0]                    i_wdata,
    input  logic [DATA_W-1:0]              i_rdata,
    output logic [DATA_W/8-1:0]            o_be,
    output logic [DATA_W-1:0]              o_wdata,
    output logic [31:0]                    o_rdata
);

    localparam int NB = DATA_W / 8;

    // Aligned access: lane l holds access byte (l mod n); replicate across the bus
    always_comb begin : store_lanes
        int n;
        int k;
        int idx;
        n       = lsu_nbytes(i_size);
        o_be    = '0;
        o_wdata = '0;
        for (int l = 0; l < NB; l++) begin
            k   = l % n;
            idx = BIG_ENDIAN ? (n - 1 - k) : k;
            o_wdata[8*l +: 8] = i_wdata[8*idx +: 8];
            if (l >= int'(i_off) && l < int'(i_off) + n)
                o_be[l] = 1'b1;
        end
    end

    // Gather the selected lanes into a right-justified value, then extend
    always_comb begin : load_lanes
        int n;
        int lane;
        int idx;
        logic [31:0] v;
        n = lsu_nbytes(i_size);
        v = '0;
        for (int k = 0; k < 4; k++) begin
            if (k < n) begin
                lane = (int'(i_off) + k) % NB;
                idx  = BIG_ENDIAN ? (n - 1 - k) : k;
                v[8*idx +: 8] = i_rdata[8*lane +: 8];
            end
        end
        case (i_size)
            SIZE_BYTE: o_rdata = {{24{i_signed & v[7]}}, v[7:0]};
            SIZE_HALF: o_rdata = {{16{i_signed & v[15]}}, v[15:0]};
            default:   o_rdata = v;
        endcase
    end

endmodule

// File: rtl/mips_bus_lsu.sv
// Load/store unit driving an Avalon-MM master port for the MIPS core.
// One access at a time: IDLE -> BUS -> RESP, with misalign and timeout errors.
module mips_bus_lsu
    import mips_bus_lsu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter bit BIG_ENDIAN = 1'b1,
    parameter int WAIT_LIMIT = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [31:0]         req_addr,
    input  logic [31:0]         req_wdata,
    output logic                resp_valid,
    output logic [31:0]         resp_rdata,
    output logic                resp_err,
    output logic [31:0]         address,
    output logic                read,
    output logic                write,
    input  logic                waitrequest,
    output logic [DATA_W-1:0]   writedata,
    output logic [DATA_W/8-1:0] byteenable,
    input  logic [DATA_W-1:0]   readdata
);

    localparam int NB = DATA_W / 8;
    localparam int OW = $clog2(NB);
    localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;

    lsu_state_t    r_state;
    lsu_state_t    w_next;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    lsu_size_t     r_size;
    logic          r_signed;
    logic          r_write;
    logic          r_err;
    logic [CW-1:0] r_wait;

    logic              w_accept;
    logic              w_misal;
    logic              w_in_bus;
    logic              w_timeout;
    logic [NB-1:0]     w_be;
    logic [DATA_W-1:0] w_wd;
    logic [31:0]       w_rd;

    assign w_in_bus  = (r_state == LSU_BUS);
    assign w_accept  = (r_state == LSU_IDLE) && req_valid;
    assign w_misal   = lsu_misaligned(lsu_size_t'(req_size), req_addr[1:0]);
    assign w_timeout = (WAIT_LIMIT != 0) && w_in_bus && waitrequest &&
                       (r_wait == CW'(WAIT_LIMIT - 1));

    mips_bus_lsu_lane_align #(
        .DATA_W     (DATA_W),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_align (
        .i_size   (r_size),
        .i_off    (r_addr[OW-1:0]),
        .i_signed (r_signed),
        .i_wdata  (r_wdata),
        .i_rdata  (readdata),
        .o_be     (w_be),
        .o_wdata  (w_wd),
        .o_rdata  (w_rd)
    );

    // State register; async reset drops bus strobes immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= LSU_IDLE;
        else        r_state <= w_next;
    end

    // Next state: misaligned requests skip the bus entirely
    always_comb begin
        w_next = r_state;
        case (r_state)
            LSU_IDLE: if (req_valid) w_next = w_misal ? LSU_RESP : LSU_BUS;
            LSU_BUS:  if (!waitrequest || w_timeout) w_next = LSU_RESP;
            LSU_RESP: w_next = LSU_IDLE;
            default:  w_next = LSU_IDLE;
        endcase
    end

    // Outputs decoded from state; lanes/data come from the latched request
    always_comb begin
        req_ready  = (r_state == LSU_IDLE);
        read       = w_in_bus && !r_write;
        write      = w_in_bus && r_write;
        address    = {r_addr[31:OW], {OW{1'b0}}};
        byteenable = w_in_bus ? w_be : '0;
        writedata  = (w_in_bus && r_write) ? w_wd : '0;
        resp_valid = (r_state == LSU_RESP);
        resp_err   = (r_state == LSU_RESP) && r_err;
        resp_rdata = (r_state == LSU_RESP) ? r_rdata : '0;
    end

    // Request latch, load capture, wait counting and error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_size   <= SIZE_BYTE;
            r_signed <= 1'b0;
            r_write  <= 1'b0;
            r_err    <= 1'b0;
            r_wait   <= '0;
        end else if (w_accept) begin
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_rdata  <= '0;
            r_size   <= lsu_size_t'(req_size);
            r_signed <= req_signed;
            r_write  <= req_write;
            r_err    <= w_misal;
            r_wait   <= '0;
        end else if (w_in_bus) begin
            if (!waitrequest) begin
                if (!r_write) r_rdata <= w_rd;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end else begin
                r_wait <= r_wait + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mips_bus_lsu.sv
// Directed bench for mips_bus_lsu: 32-bit big-endian with WAIT_LIMIT=8,
// plus a 64-bit instance for wide lane mapping.
module tb_mips_bus_lsu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        waitrequest;
    logic [31:0] readdata;

    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;

    logic        v64;
    logic        wait64;
    logic [63:0] rdat64;
    logic        rdy64;
    logic        rv64;
    logic [31:0] rr64;
    logic        re64;
    logic [31:0] ad64;
    logic        rd64;
    logic        wr64;
    logic [63:0] wd64;
    logic [7:0]  be64;

    int n_err = 0;
    int n_chk = 0;
    int cnt;

    mips_bus_lsu #(.DATA_W(32), .BIG_ENDIAN(1'b1), .WAIT_LIMIT(8)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .address     (address),
        .read        (read),
        .write       (write),
        .waitrequest (waitrequest),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .readdata    (readdata)
    );

    mips_bus_lsu #(.DATA_W(64), .BIG_ENDIAN(1'b1), .WAIT_LIMIT(0)) dut64 (
        .clk         (clk),
        .reset       (rst_n),
        .req_valid   (v64),
        .req_ready   (rdy64),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (rv64),
        .resp_rdata  (rr64),
        .resp_err    (re64),
        .address     (ad64),
        .read        (rd64),
        .write       (wr64),
        .waitrequest (wait64),
        .writedata   (wd64),
        .byteenable  (be64),
        .readdata    (rdat64)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request, check ready, take the accept edge, drop valid
    task automatic issue(input logic wr, input logic [1:0] sz,
                         input logic sg, input logic [31:0] ad,
                         input logic [31:0] wd);
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = ad;
        req_wdata  = wd;
        req_valid  = 1'b1;
        chk("ready_before_accept", req_ready, 1'b1);
        tick();
        req_valid  = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_size    = 2'b00;
        req_signed  = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        waitrequest = 1'b0;
        readdata    = '0;
        v64         = 1'b0;
        wait64      = 1'b0;
        rdat64      = '0;
        tick();
        tick();

        chk("rst_ready", req_ready, 1'b1);
        chk("rst_read", read, 1'b0);
        chk("rst_write", write, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_err", resp_err, 1'b0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_address", address, 32'h0);
        chk("rst_be", byteenable, 4'h0);
        chk("rst_wdata", writedata, 32'h0);
        chk("rst64_ready", rdy64, 1'b1);
        chk("rst64_be", be64, 8'h00);
        rst_n = 1'b1;
        tick();

        // LW 0x1000, zero wait
        readdata = 32'h7856_3412;
        issue(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0);
        chk("lw_read", read, 1'b1);
        chk("lw_addr", address, 32'h1000);
        chk("lw_be", byteenable, 4'hF);
        chk("lw_not_ready", req_ready, 1'b0);
        chk("lw_no_early_resp", resp_valid, 1'b0);
        tick();
        chk("lw_resp_valid", resp_valid, 1'b1);
        chk("lw_rdata", resp_rdata, 32'h1234_5678);
        chk("lw_err", resp_err, 1'b0);
        chk("lw_read_drop", read, 1'b0);
        tick();
        chk("lw_resp_pulse", resp_valid, 1'b0);
        chk("lw_back_idle", req_ready, 1'b1);

        // LB 0x1003 signed, then LBU
        readdata = 32'h8000_0000;
        issue(1'b0, 2'b00, 1'b1, 32'h1003, 32'h0);
        chk("lb_be", byteenable, 4'b1000);
        chk("lb_addr", address, 32'h1000);
        tick();
        chk("lb_rdata", resp_rdata, 32'hFFFF_FF80);
        tick();
        issue(1'b0, 2'b00, 1'b0, 32'h1003, 32'h0);
        tick();
        chk("lbu_rdata", resp_rdata, 32'h0000_0080);
        tick();

        // LH 0x1000 signed: lanes 0,1 = 0x84,0x34 -> 0x8434
        readdata = 32'h0000_3484;
        issue(1'b0, 2'b01, 1'b1, 32'h1000, 32'h0);
        chk("lh_be", byteenable, 4'b0011);
        tick();
        chk("lh_rdata", resp_rdata, 32'hFFFF_8434);
        tick();

        // SH 0x1002 with three wait cycles
        issue(1'b1, 2'b01, 1'b0, 32'h1002, 32'h0000_ABCD);
        waitrequest = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) waitrequest = 1'b0;
            chk("sh_write_held", write, 1'b1);
            chk("sh_read_low", read, 1'b0);
            chk("sh_addr", address, 32'h1000);
            chk("sh_be", byteenable, 4'b1100);
            chk("sh_lanes", writedata[31:16], 16'hCDAB);
            chk("sh_no_resp", resp_valid, 1'b0);
            tick();
        end
        chk("sh_resp_valid", resp_valid, 1'b1);
        chk("sh_write_drop", write, 1'b0);
        chk("sh_rdata_zero", resp_rdata, 32'h0);
        chk("sh_err", resp_err, 1'b0);
        tick();

        // SW 0x1004: big-endian word onto all lanes
        issue(1'b1, 2'b10, 1'b0, 32'h1004, 32'h1122_3344);
        chk("sw_addr", address, 32'h1004);
        chk("sw_be", byteenable, 4'hF);
        chk("sw_wdata", writedata, 32'h4433_2211);
        tick();
        chk("sw_resp", resp_valid, 1'b1);
        tick();

        // Misaligned LW 0x1002
        issue(1'b0, 2'b10, 1'b0, 32'h1002, 32'h0);
        chk("mis_read", read, 1'b0);
        chk("mis_resp_valid", resp_valid, 1'b1);
        chk("mis_err", resp_err, 1'b1);
        tick();
        chk("mis_idle", req_ready, 1'b1);
        chk("mis_read_after", read, 1'b0);

        // Timeout: waitrequest stuck high
        issue(1'b0, 2'b10, 1'b0, 32'h2000, 32'h0);
        waitrequest = 1'b1;
        cnt = 0;
        while (read && cnt < 20) begin
            cnt++;
            tick();
        end
        chk("to_read_cycles", cnt, 8);
        chk("to_resp_valid", resp_valid, 1'b1);
        chk("to_err", resp_err, 1'b1);
        waitrequest = 1'b0;
        tick();
        chk("to_idle", req_ready, 1'b1);
        readdata = 32'h0000_00C3;
        issue(1'b0, 2'b00, 1'b0, 32'h2000, 32'h0);
        tick();
        chk("to_next_resp", resp_valid, 1'b1);
        chk("to_next_rdata", resp_rdata, 32'h0000_00C3);
        chk("to_next_err", resp_err, 1'b0);
        tick();

        // Reset asserted mid-BUS
        waitrequest = 1'b1;
        issue(1'b0, 2'b10, 1'b0, 32'h3000, 32'h0);
        chk("rb_read_high", read, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rb_read_async", read, 1'b0);
        chk("rb_no_resp", resp_valid, 1'b0);
        tick();
        rst_n = 1'b1;
        waitrequest = 1'b0;
        chk("rb_ready", req_ready, 1'b1);
        tick();
        chk("rb_no_resp_after", resp_valid, 1'b0);
        chk("rb_ready_after", req_ready, 1'b1);

        // 64-bit LH 0x1006: lanes 6,7 = 0xAA,0xBB
        rdat64     = 64'hBBAA_0000_0000_0000;
        req_write  = 1'b0;
        req_size   = 2'b01;
        req_signed = 1'b1;
        req_addr   = 32'h1006;
        v64        = 1'b1;
        chk("w64_ready", rdy64, 1'b1);
        tick();
        v64 = 1'b0;
        chk("w64_read", rd64, 1'b1);
        chk("w64_be", be64, 8'hC0);
        chk("w64_addr", ad64, 32'h1000);
        tick();
        chk("w64_resp", rv64, 1'b1);
        chk("w64_rdata", rr64, 32'hFFFF_AABB);
        chk("w64_err", re64, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
